agc_ctrl: RTL and testbench
===========================

# agc_ctrl

Automatic-gain-control sequencer for the AGC datapath. It measures mean absolute amplitude and saturation events over a fixed window of post-cast samples from the PARALLEL-lane signed stream. From that measurement it steps a registered gain (shift) word up or down by one, then holds off for a settle period so the downstream scaler and cast pipeline can flush before the next measurement. It sits beside the cast/scaler chain: it observes that chain's output stream and drives its gain select.

## Interface
- PARALLEL, 4: lanes per beat
- DIN_WIDTH, 8: signed sample width per lane (two's complement; binary point irrelevant here)
- WINDOW_LOG2, 10: measurement window = 2**WINDOW_LOG2 valid beats
- GAIN_WIDTH, 4: gain word width
- GAIN_MAX, 15: highest gain code
- GAIN_INIT, 8: gain after reset
- SETTLE_CYCLES, 16: clocks to ignore data after a gain change (≥1)
- ACC_W (localparam): DIN_WIDTH + clog2(PARALLEL) + WINDOW_LOG2
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  run control; low forces IDLE, gain held
- din  in  DIN_WIDTH*PARALLEL  lane i at [DIN_WIDTH*i +: DIN_WIDTH]
- din_valid  in  1  beat qualifier
- target_hi  in  ACC_W  window sum above which gain decrements
- target_lo  in  ACC_W  window sum below which gain increments
- gain  out  GAIN_WIDTH  current gain code
- gain_update  out  1  one-cycle pulse when gain changes
- power  out  ACC_W  last completed window sum
- sat_seen  out  1  last window contained a full-scale sample
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACCUM, FLUSH, DECIDE, SETTLE.
- IDLE: acc, beat counter and sat flag cleared; enable=1 → ACCUM next clock.
- ACCUM: each valid beat enters stage 1, which registers the sum over lanes of |x|, plus a sat bit = any lane equal to 2**(DIN_WIDTH-1)-1 or -2**(DIN_WIDTH-1).
  - |−2**(DIN_WIDTH-1)| = 2**(DIN_WIDTH-1); no wrap.
  - Stage 2 adds the stage-1 result into acc and ORs in the sat bit.
  - The beat counter increments per valid beat; on the 2**WINDOW_LOG2-th beat → FLUSH.
- FLUSH: one cycle so the last beat reaches acc; → DECIDE.
- DECIDE: latch power←acc and sat_seen←sat, then choose the gain action:
  - if sat or acc > target_hi: gain−1, floored at 0.
  - else if acc < target_lo: gain+1, capped at GAIN_MAX.
  - else hold.
  - gain_update=1 only if the gain code actually changes.
  - Clear acc, counter and sat. Gain changed → SETTLE; unchanged → ACCUM.
- SETTLE: count SETTLE_CYCLES clocks with din ignored; → ACCUM.
- Beats arriving in FLUSH, DECIDE, SETTLE or IDLE are discarded and not counted.
- enable falling in any state → IDLE next clock. The partial window is discarded; gain, power and sat_seen are held.
- Priority: rst_n over enable over the state logic.
- Comparisons are unsigned, strict (> / <). If target_lo > target_hi, the decrement rule wins.

## Timing
- Reset values: gain=GAIN_INIT, gain_update=0, power=0, sat_seen=0, busy=0, state=IDLE.
- The last window beat is accepted at edge n. FLUSH runs during n..n+1 and DECIDE during n+1..n+2. power, sat_seen and gain update at edge n+2, with gain_update high for the cycle following edge n+2.
- Minimum measurement period = 2**WINDOW_LOG2 + 2 beats/clocks. Add SETTLE_CYCLES when gain changes.
- Full-rate input is supported: no backpressure, din_valid may be high every clock.
- Reset mid-window aborts it with no gain change.

## Structure
- Shared package agc_pkg: state enum, ACC_W function (clog2-based), full-scale constants derived from DIN_WIDTH.
- One sub-module, agc_abs_sum: stage-1 per-lane abs, lane adder tree and sat detect, registered, 1-cycle latency.
- The FSM, counters and gain register live in agc_ctrl.

## Test plan
- Reset with WINDOW_LOG2=2, GAIN_INIT=8: all outputs at reset values. enable=1, 4 beats of all lanes =10, target_lo=200, target_hi=300 → power=160, gain 8→9, one gain_update pulse two clocks after the 4th beat.
- Same stimulus with targets lo=100, hi=200 → power=160, gain stays 8, no pulse, FSM returns directly to ACCUM (no SETTLE).
- One lane = −128 in one beat (DIN_WIDTH=8), rest small → sat_seen=1, gain decrements. Repeat until gain=0, then verify the floor holds with no pulse.
- Gain at GAIN_MAX with low input → no increment, no pulse.
- din_valid toggled randomly and enable dropped mid-window → only valid beats counted; after the drop, FSM in IDLE and gain/power unchanged.
- rst_n low during SETTLE → next cycle gain=GAIN_INIT, busy=0. Beats sent during SETTLE must not appear in the next power.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared types and width helpers for the AGC sequencer slice.
package agc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FLUSH,
        ST_DECIDE,
        ST_SETTLE
    } state_t;

    // Width of one beat's lane-sum of magnitudes; |-2**(d-1)| needs no extra bit.
    function automatic int sum_width(input int din_w, input int lanes);
        return din_w + $clog2(lanes);
    endfunction

    function automatic int acc_width(input int din_w, input int lanes, input int window_log2);
        return sum_width(din_w, lanes) + window_log2;
    endfunction

    function automatic logic [31:0] full_scale_pos(input int din_w);
        return (32'd1 << (din_w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] full_scale_neg(input int din_w);
        return 32'd1 << (din_w - 1);
    endfunction

endpackage

// File: rtl/agc_abs_sum.sv
// Stage 1: per-lane magnitude, lane adder tree and full-scale detect, one register deep.
module agc_abs_sum
    import agc_pkg::*;
#(
    parameter int PARALLEL  = 4,
    parameter int DIN_WIDTH = 8,
    localparam int SUM_W    = sum_width(DIN_WIDTH, PARALLEL)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIN_WIDTH*PARALLEL-1:0] din,
    input  logic                          beat_valid,
    output logic [SUM_W-1:0]              sum,
    output logic                          sat,
    output logic                          sum_valid
);

    localparam logic [DIN_WIDTH-1:0] FS_POS = DIN_WIDTH'(full_scale_pos(DIN_WIDTH));
    localparam logic [DIN_WIDTH-1:0] FS_NEG = DIN_WIDTH'(full_scale_neg(DIN_WIDTH));

    logic [SUM_W-1:0] sum_c;
    logic             sat_c;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sum_c = '0;
        sat_c = 1'b0;
        for (int i = 0; i < PARALLEL; i++) begin
            logic [DIN_WIDTH-1:0] lane;
            logic [DIN_WIDTH-1:0] inv;
            logic [SUM_W-1:0]     mag;
            lane  = din[DIN_WIDTH*i +: DIN_WIDTH];
            inv   = ~lane;
            mag   = lane[DIN_WIDTH-1] ? SUM_W'(inv) + SUM_W'(1) : SUM_W'(lane);
            sum_c = sum_c + mag;
            sat_c = sat_c | (lane == FS_POS) | (lane == FS_NEG);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= '0;
            sat       <= 1'b0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= beat_valid;
            if (beat_valid) begin
                sum <= sum_c;
                sat <= sat_c;
            end
        end
    end

endmodule

// File: rtl/agc_ctrl.sv
// AGC sequencer: windowed amplitude measurement, one-step gain adjust, settle hold-off.
module agc_ctrl
    import agc_pkg::*;
#(
    parameter int PARALLEL      = 4,
    parameter int DIN_WIDTH     = 8,
    parameter int WINDOW_LOG2   = 10,
    parameter int GAIN_WIDTH    = 4,
    parameter int GAIN_MAX      = 15,
    parameter int GAIN_INIT     = 8,
    parameter int SETTLE_CYCLES = 16,
    localparam int ACC_W        = acc_width(DIN_WIDTH, PARALLEL, WINDOW_LOG2)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DIN_WIDTH*PARALLEL-1:0] din,
    input  logic                          din_valid,
    input  logic [ACC_W-1:0]              target_hi,
    input  logic [ACC_W-1:0]              target_lo,
    output logic [GAIN_WIDTH-1:0]         gain,
    output logic                          gain_update,
    output logic [ACC_W-1:0]              power,
    output logic                          sat_seen,
    output logic                          busy
);

    localparam int SUM_W = sum_width(DIN_WIDTH, PARALLEL);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    state_t                  state_q, state_d;
    logic [WINDOW_LOG2-1:0]  beat_cnt;
    logic [SET_W-1:0]        settle_cnt;
    logic [ACC_W-1:0]        acc;
    logic                    sat_acc;
    logic [SUM_W-1:0]        s1_sum;
    logic                    s1_sat;
    logic                    s1_valid;
    logic                    accept;
    logic                    last_beat;
    logic                    settle_done;
    logic                    clear_window;
    logic                    go_down;
    logic                    go_up;
    logic [GAIN_WIDTH-1:0]   gain_d;
    logic                    gain_chg;

    assign accept       = enable && (state_q == ST_ACCUM) && din_valid;
    assign last_beat    = accept && (beat_cnt == '1);
    assign settle_done  = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
    assign clear_window = !enable || (state_q == ST_IDLE) || (state_q == ST_DECIDE);
    assign busy         = (state_q != ST_IDLE);

    agc_abs_sum #(
        .PARALLEL  (PARALLEL),
        .DIN_WIDTH (DIN_WIDTH)
    ) u_abs_sum (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .beat_valid (accept),
        .sum        (s1_sum),
        .sat        (s1_sat),
        .sum_valid  (s1_valid)
    );

    // Decrement wins over increment, which also covers target_lo > target_hi.
    always_comb begin
        go_down = sat_acc || (acc > target_hi);
        go_up   = !go_down && (acc < target_lo);
        gain_d  = gain;
        if (go_down && (gain != '0))
            gain_d = gain - GAIN_WIDTH'(1);
        else if (go_up && (gain != GAIN_WIDTH'(GAIN_MAX)))
            gain_d = gain + GAIN_WIDTH'(1);
        gain_chg = (gain_d != gain);
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_ACCUM;
                ST_ACCUM:  if (last_beat) state_d = ST_FLUSH;
                ST_FLUSH:  state_d = ST_DECIDE;
                ST_DECIDE: state_d = gain_chg ? ST_SETTLE : ST_ACCUM;
                ST_SETTLE: if (settle_done) state_d = ST_ACCUM;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt    <= '0;
            settle_cnt  <= '0;
            acc         <= '0;
            sat_acc     <= 1'b0;
            gain        <= GAIN_WIDTH'(GAIN_INIT);
            gain_update <= 1'b0;
            power       <= '0;
            sat_seen    <= 1'b0;
        end else begin
            gain_update <= 1'b0;
            settle_cnt  <= (enable && state_q == ST_SETTLE) ? settle_cnt + SET_W'(1) : '0;

            if (clear_window) begin
                beat_cnt <= '0;
                acc      <= '0;
                sat_acc  <= 1'b0;
            end else begin
                if (accept)
                    beat_cnt <= beat_cnt + WINDOW_LOG2'(1);
                if (s1_valid) begin
                    acc     <= acc + ACC_W'(s1_sum);
                    sat_acc <= sat_acc | s1_sat;
                end
            end

            if (enable && state_q == ST_DECIDE) begin
                power       <= acc;
                sat_seen    <= sat_acc;
                gain        <= gain_d;
                gain_update <= gain_chg;
            end
        end
    end

endmodule

// File: tb/tb_agc_ctrl.sv
// Self-checking bench for agc_ctrl against a window/timestamp-level reference model.
module tb_agc_ctrl;
    import agc_pkg::*;

    localparam int PARALLEL  = 4;
    localparam int DIN_WIDTH = 8;
    localparam int WLOG2     = 2;
    localparam int WIN       = 1 << WLOG2;
    localparam int GW        = 4;
    localparam int GMAX      = 15;
    localparam int GINIT     = 8;
    localparam int SETTLE    = 4;
    localparam int ACC_W     = acc_width(DIN_WIDTH, PARALLEL, WLOG2);

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          enable = 1'b0;
    logic [DIN_WIDTH*PARALLEL-1:0] din = '0;
    logic                          din_valid = 1'b0;
    logic [ACC_W-1:0]              target_hi = '0;
    logic [ACC_W-1:0]              target_lo = '0;
    logic [GW-1:0]                 gain;
    logic                          gain_update;
    logic [ACC_W-1:0]              power;
    logic                          sat_seen;
    logic                          busy;

    agc_ctrl #(
        .PARALLEL      (PARALLEL),
        .DIN_WIDTH     (DIN_WIDTH),
        .WINDOW_LOG2   (WLOG2),
        .GAIN_WIDTH    (GW),
        .GAIN_MAX      (GMAX),
        .GAIN_INIT     (GINIT),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .din         (din),
        .din_valid   (din_valid),
        .target_hi   (target_hi),
        .target_lo   (target_lo),
        .gain        (gain),
        .gain_update (gain_update),
        .power       (power),
        .sat_seen    (sat_seen),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks the window as a running sum, and the blind intervals
    // (flush/decide/settle) as an edge index before which no beat is accepted.
    int cyc = 0;
    bit m_idle = 1;
    int m_sum = 0, m_cnt = 0;
    bit m_sat = 0;
    int m_block = 0;
    int m_dec_edge = -1;
    int m_pend_gain = 0, m_pend_pow = 0;
    bit m_pend_sat = 0;
    int e_gain = GINIT, e_power = 0;
    bit e_sat = 0, e_upd = 0;

    function automatic int beat_mag(input logic [31:0] d);
        int s = 0;
        for (int i = 0; i < PARALLEL; i++) begin
            logic signed [7:0] x;
            x = d[8*i +: 8];
            s += (x < 0) ? -int'(x) : int'(x);
        end
        return s;
    endfunction

    function automatic bit beat_sat(input logic [31:0] d);
        bit s = 0;
        for (int i = 0; i < PARALLEL; i++) begin
            logic signed [7:0] x;
            x = d[8*i +: 8];
            if (x == 127 || x == -128) s = 1;
        end
        return s;
    endfunction

    function automatic logic [31:0] rep4(input logic [7:0] b);
        return {b, b, b, b};
    endfunction

    task automatic model_clear();
        m_sum = 0; m_cnt = 0; m_sat = 0; m_dec_edge = -1;
    endtask

    task automatic model_edge(input bit rn, input bit en, input bit v, input logic [31:0] d);
        int ng;
        cyc++;
        e_upd = 0;
        if (!rn) begin
            m_idle = 1; model_clear();
            e_gain = GINIT; e_power = 0; e_sat = 0;
        end else if (!en) begin
            m_idle = 1; model_clear();
        end else if (m_idle) begin
            m_idle = 0; model_clear(); m_block = cyc;
        end else if (cyc == m_dec_edge) begin
            e_upd   = (m_pend_gain != e_gain);
            e_gain  = m_pend_gain;
            e_power = m_pend_pow;
            e_sat   = m_pend_sat;
            m_dec_edge = -1;
        end else if (v && cyc > m_block) begin
            m_sum += beat_mag(d);
            m_sat |= beat_sat(d);
            m_cnt++;
            if (m_cnt == WIN) begin
                if (m_sat || m_sum > int'(target_hi))      ng = (e_gain > 0) ? e_gain - 1 : 0;
                else if (m_sum < int'(target_lo))          ng = (e_gain < GMAX) ? e_gain + 1 : GMAX;
                else                                       ng = e_gain;
                m_pend_gain = ng; m_pend_pow = m_sum; m_pend_sat = m_sat;
                m_sum = 0; m_cnt = 0; m_sat = 0;
                m_dec_edge = cyc + 2;
                m_block = cyc + 2 + ((ng != e_gain) ? SETTLE : 0);
            end
        end
    endtask

    task automatic step(input bit rn, input bit en, input bit v, input logic [31:0] d);
        rst_n = rn; enable = en; din_valid = v; din = d;
        @(posedge clk);
        model_edge(rn, en, v, d);
        #1;
        pulses += int'(gain_update);
        check("gain", 32'(gain), 32'(e_gain));
        check("gain_update", 32'(gain_update), 32'(e_upd));
        check("power", 32'(power), 32'(e_power));
        check("sat_seen", 32'(sat_seen), 32'(e_sat));
        check("busy", 32'(busy), 32'(!m_idle));
    endtask

    function automatic logic [31:0] rand_beat(input int fs_chance);
        logic [31:0] d;
        for (int i = 0; i < PARALLEL; i++) begin
            if ($urandom_range(fs_chance) == 0) d[8*i +: 8] = ($urandom_range(1) == 0) ? 8'h7f : 8'h80;
            else                                d[8*i +: 8] = 8'($urandom_range(253) - 126);
        end
        return d;
    endfunction

    task automatic small_beats(input int n);
        for (int k = 0; k < n; k++) step(1, 1, 1, {4{8'($urandom_range(7))}});
    endtask

    int saved_gain, saved_pow;

    initial begin
        // Reset state
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        check("rst_gain", 32'(gain), GINIT);
        check("rst_power", 32'(power), 0);
        check("rst_sat", 32'(sat_seen), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_upd", 32'(gain_update), 0);

        // Low window: 4 beats of 10 -> power 160, gain 8->9, pulse two clocks after last beat
        target_lo = 200; target_hi = 300; pulses = 0;
        for (int k = 0; k < 5; k++) step(1, 1, 1, rep4(8'd10));
        step(1, 1, 0, '0);
        check("up_early_upd", 32'(gain_update), 0);
        step(1, 1, 0, '0);
        check("up_power", 32'(power), 160);
        check("up_gain", 32'(gain), 9);
        check("up_upd", 32'(gain_update), 1);
        for (int k = 0; k < 4; k++) step(1, 1, 0, '0);
        check("up_pulses", pulses, 1);
        step(1, 0, 0, '0);

        // In-band window: gain holds, no settle
        step(0, 0, 0, '0);
        target_lo = 100; target_hi = 200; pulses = 0;
        for (int k = 0; k < 5; k++) step(1, 1, 1, rep4(8'd10));
        step(1, 1, 0, '0);
        step(1, 1, 0, '0);
        check("hold_power", 32'(power), 160);
        check("hold_gain", 32'(gain), GINIT);
        check("hold_pulses", pulses, 0);
        check("hold_state", 32'(dut.state_q), 32'(ST_ACCUM));
        step(1, 0, 0, '0);

        // Saturation drives gain to the floor
        target_lo = 0; target_hi = '1; pulses = 0;
        for (int k = 0; k < 120; k++) step(1, 1, 1, {8'd1, 8'd2, 8'd3, 8'h80});
        check("floor_gain", 32'(gain), 0);
        check("floor_sat", 32'(sat_seen), 1);
        check("floor_pulses", pulses, GINIT);
        pulses = 0;
        for (int k = 0; k < 40; k++) step(1, 1, 1, {8'd1, 8'd2, 8'd3, 8'h80});
        check("floor_hold_pulses", pulses, 0);
        step(1, 0, 0, '0);

        // Low input drives gain to the ceiling
        step(0, 0, 0, '0);
        target_lo = '1; target_hi = '1; pulses = 0;
        small_beats(100);
        check("ceil_gain", 32'(gain), GMAX);
        pulses = 0;
        small_beats(40);
        check("ceil_hold_pulses", pulses, 0);
        step(1, 0, 0, '0);

        // Enable drop mid-window
        target_lo = 0; target_hi = '1;
        step(1, 1, 0, '0);
        step(1, 1, 1, rep4(8'd50));
        step(1, 1, 0, '0);
        step(1, 1, 1, rep4(8'd50));
        saved_gain = e_gain; saved_pow = e_power;
        step(1, 0, 1, rep4(8'd50));
        check("drop_busy", 32'(busy), 0);
        check("drop_gain", 32'(gain), saved_gain);
        check("drop_power", 32'(power), saved_pow);

        // Randomised traffic with sporadic enable drops
        step(0, 0, 0, '0);
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(60) == 0) begin
                for (int j = 0; j < int'($urandom_range(3)) + 1; j++) begin
                    target_lo = ACC_W'($urandom_range(2100));
                    target_hi = ACC_W'($urandom_range(2100));
                    step(1, 0, $urandom_range(1), rand_beat(8));
                end
            end else begin
                step(1, 1, $urandom_range(1), rand_beat(40));
            end
        end
        step(1, 0, 0, '0);

        // Reset during SETTLE; settle-time beats must not leak into next window
        step(0, 0, 0, '0);
        target_lo = 200; target_hi = 300;
        for (int k = 0; k < 5; k++) step(1, 1, 1, rep4(8'd10));
        step(1, 1, 0, '0);
        step(1, 1, 0, '0);
        check("settle_entry", 32'(dut.state_q), 32'(ST_SETTLE));
        step(1, 1, 1, rep4(8'd100));
        step(1, 1, 1, rep4(8'd100));
        step(0, 1, 1, rep4(8'd100));
        check("settle_rst_gain", 32'(gain), GINIT);
        check("settle_rst_busy", 32'(busy), 0);
        for (int k = 0; k < 5; k++) step(1, 1, 1, rep4(8'd20));
        step(1, 1, 0, '0);
        step(1, 1, 0, '0);
        check("post_rst_power", 32'(power), 320);
        check("post_rst_gain", 32'(gain), GINIT - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
